game_round_ctrl: RTL and testbench

//  Round sequencer for the 0..9 stop-the-counter game. Owns the game counter's
//  run/stop/clear control and generates its count tick from the system clock.

---
 rtl/game_round_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: run/stop/score/round sequencer for the 0..9 stop-the-counter game.
// Define RAND_TARGET_EN to draw each round's target from a free-running 8-bit LFSR.
module game_round_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SHOW_CYCLES = 100_000_000,
  parameter int ROUNDS      = 5,
  parameter int TARGET      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  output logic [3:0] count_out,
  output logic [3:0] target_out,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic [1:0] state_out,
  output logic       hit,
  output logic       game_over
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [SHOW_W-1:0] SHOW_MAX = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [3:0] ROUNDS_V = 4'(ROUNDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  logic [2:0]        start_sync_q, stop_sync_q;
  logic              start_edge, stop_edge;
  logic [1:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        target_q, target_d;
  logic [3:0]        score_q, score_d;
  logic [3:0]        round_q, round_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SHOW_W-1:0] show_q, show_d;
  logic              hit_q, hit_d;
  logic              game_over_q;
  logic [3:0]        next_target;

`ifdef RAND_TARGET_EN
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [3:0] TARGET_RST = LFSR_SEED[3:0];

  logic [7:0] lfsr_q;

  function automatic logic [3:0] fold_digit(input logic [3:0] t);
    return (t > 4'd9) ? (t - 4'd10) : t;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4, stepping every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign next_target = fold_digit(lfsr_q[3:0]);
`else
  localparam logic [3:0] TARGET_RST = 4'(TARGET);

  assign next_target = TARGET_RST;
`endif

  // Two-flop synchronisers plus a history flop per button for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= 3'b000;
      stop_sync_q  <= 3'b000;
    end else begin
      start_sync_q <= {start_sync_q[1:0], btn_start};
      stop_sync_q  <= {stop_sync_q[1:0], btn_stop};
    end
  end

  assign start_edge = start_sync_q[1] & ~start_sync_q[2];
  assign stop_edge  = stop_sync_q[1] & ~stop_sync_q[2];

  // Round sequencer next-state logic
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    score_d  = score_q;
    round_d  = round_q;
    tick_d   = tick_q;
    show_d   = show_q;
    hit_d    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d  = S_RUN;
          count_d  = 4'd0;
          tick_d   = '0;
          target_d = next_target;
          score_d  = 4'd0;
          round_d  = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // A stop edge wins over a tick landing in the same cycle
        if (stop_edge) begin
          state_d = S_RESULT;
          show_d  = '0;
          if (count_q == target_q) begin
            hit_d   = 1'b1;
            score_d = (score_q == 4'd9) ? 4'd9 : (score_q + 4'd1);
          end else begin
            hit_d = 1'b0;
          end
        end else if (tick_q == TICK_MAX) begin
          tick_d  = '0;
          count_d = (count_q == 4'd9) ? 4'd0 : (count_q + 4'd1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_RESULT: begin
        if (show_q == SHOW_MAX) begin
          round_d = round_q + 4'd1;
          if ((round_q + 4'd1) == ROUNDS_V) begin
            state_d = S_OVER;
          end else begin
            state_d  = S_RUN;
            count_d  = 4'd0;
            tick_d   = '0;
            target_d = next_target;
          end
        end else begin
          show_d = show_q + SHOW_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      target_q    <= TARGET_RST;
      score_q     <= 4'd0;
      round_q     <= 4'd0;
      tick_q      <= '0;
      show_q      <= '0;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      score_q     <= score_d;
      round_q     <= round_d;
      tick_q      <= tick_d;
      show_q      <= show_d;
      hit_q       <= hit_d;
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign count_out  = count_q;
  assign target_out = target_q;
  assign score      = score_q;
  assign round      = round_q;
  assign state_out  = state_q;
  assign hit        = hit_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: timing-based reference model, randomized stop points.
module tb_game_round_ctrl;

  localparam int TDIV = 4;
  localparam int SHOW = 8;
  localparam int NR   = 3;
  localparam int TGT  = 7;
  localparam logic [7:0] SEED = 8'hA5;
`ifdef RAND_TARGET_EN
  localparam logic [3:0] RST_TGT = 4'(SEED[3:0] % 10);
`else
  localparam logic [3:0] RST_TGT = 4'(TGT);
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic [3:0] count_out, target_out, score, round;
  logic [1:0] state_out;
  logic       hit, game_over;

  int errors = 0;
  int checks = 0;
  int run_k  = 0;
  logic [3:0] exp_target = RST_TGT;
  logic [3:0] exp_score  = 4'd0;
  logic [3:0] exp_round  = 4'd0;
  logic [7:0] lfsr_m, lfsr_prev;

  game_round_ctrl #(
    .TICK_DIV(TDIV), .SHOW_CYCLES(SHOW), .ROUNDS(NR), .TARGET(TGT)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .count_out(count_out), .target_out(target_out), .score(score), .round(round),
    .state_out(state_out), .hit(hit), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR; lfsr_prev is the value seen by the DUT in the cycle before an edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_m    <= SEED;
      lfsr_prev <= SEED;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
    end
  end

  function automatic logic [3:0] round_target();
`ifdef RAND_TARGET_EN
    return 4'(lfsr_prev[3:0] % 10);
`else
    return 4'(TGT);
`endif
  endfunction

  // Counter value k clocks after entering RUN
  function automatic logic [3:0] exp_count(input int k);
    return 4'((k / TDIV) % 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    run_k++;
  endtask

  // Pulse the buttons for one clock; returns just after the edge where the FSM reacts
  task automatic pulse(input bit s, input bit p);
    btn_start = s;
    btn_stop  = p;
    step();
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    step();
    step();
  endtask

  task automatic enter_run();
    run_k      = 0;
    exp_target = round_target();
  endtask

  task automatic stop_at(input logic [3:0] c, input bit with_start);
    for (int i = 0; i < 48 && exp_count(run_k + 2) != c; i++) step();
    pulse(with_start, 1'b1);
  endtask

  task automatic play_round(input logic [3:0] c, input bit noise, input bit both);
    logic exp_hit;
    stop_at(c, both);
    exp_hit = (c == exp_target);
    if (exp_hit) exp_score = (exp_score == 4'd9) ? 4'd9 : exp_score + 4'd1;
    checks++;
    if ({state_out, count_out, hit, score} !== {2'd2, c, exp_hit, exp_score}) begin
      errors++;
      $display("FAIL result_entry got st=%0d cnt=%0d hit=%0d sc=%0d exp st=2 cnt=%0d hit=%0d sc=%0d",
               state_out, count_out, hit, score, c, exp_hit, exp_score);
    end
    if (noise) begin
      pulse(1'b1, 1'b1);
      step();
      pulse(1'b1, 1'b0);
    end else begin
      repeat (SHOW - 1) step();
    end
    checks++;
    if ({state_out, count_out, hit, score, round} !== {2'd2, c, 1'b0, exp_score, exp_round}) begin
      errors++;
      $display("FAIL result_hold got st=%0d cnt=%0d hit=%0d sc=%0d rd=%0d exp st=2 cnt=%0d hit=0 sc=%0d rd=%0d",
               state_out, count_out, hit, score, round, c, exp_score, exp_round);
    end
    step();
    exp_round = exp_round + 4'd1;
    if (exp_round == 4'(NR)) begin
      checks++;
      if ({state_out, game_over, round, score} !== {2'd3, 1'b1, exp_round, exp_score}) begin
        errors++;
        $display("FAIL game_over got st=%0d go=%0d rd=%0d sc=%0d exp st=3 go=1 rd=%0d sc=%0d",
                 state_out, game_over, round, score, exp_round, exp_score);
      end
    end else begin
      enter_run();
      checks++;
      if ({state_out, count_out, round, target_out, game_over} !== {2'd1, 4'd0, exp_round, exp_target, 1'b0}) begin
        errors++;
        $display("FAIL next_round got st=%0d cnt=%0d rd=%0d tgt=%0d exp st=1 cnt=0 rd=%0d tgt=%0d",
                 state_out, count_out, round, target_out, exp_round, exp_target);
      end
      checks++;
      if (target_out > 4'd9) begin
        errors++;
        $display("FAIL target_range got tgt=%0d exp <=9", target_out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({count_out, score, round, state_out, hit, game_over, target_out} !== {16'h0, RST_TGT}) begin
      errors++;
      $display("FAIL reset_values got cnt=%0d sc=%0d rd=%0d st=%0d hit=%0d go=%0d tgt=%0d exp zeros tgt=%0d",
               count_out, score, round, state_out, hit, game_over, target_out, RST_TGT);
    end
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (state_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle got st=%0d exp 0", state_out);
    end
  endtask

  task automatic test_run_count();
    btn_start = 1'b1;
    repeat (3) step();
    enter_run();
    checks++;
    if ({state_out, target_out} !== {2'd1, exp_target}) begin
      errors++;
      $display("FAIL run_entry got st=%0d tgt=%0d exp st=1 tgt=%0d", state_out, target_out, exp_target);
    end
    for (int i = 0; i <= 40; i++) begin
      checks++;
      if (count_out !== exp_count(run_k)) begin
        errors++;
        $display("FAIL run_count k=%0d got %0d exp %0d", run_k, count_out, exp_count(run_k));
      end
      if (i < 40) step();
    end
    btn_start = 1'b0;
    step();
    checks++;
    if (state_out !== 2'd1) begin
      errors++;
      $display("FAIL run_held got st=%0d exp 1", state_out);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 48 && exp_count(run_k) != 4'd5; i++) step();
    checks++;
    if (count_out !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_count got %0d exp 5", count_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count_out, score, round, state_out, hit, game_over, target_out} !== {16'h0, RST_TGT}) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d st=%0d tgt=%0d exp cnt=0 st=0 tgt=%0d",
               count_out, state_out, target_out, RST_TGT);
    end
    step();
    rst = 1'b0;
    repeat (5) step();
    checks++;
    if ({state_out, count_out} !== {2'd0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_idle got st=%0d cnt=%0d exp st=0 cnt=0", state_out, count_out);
    end
    exp_score = 4'd0;
    exp_round = 4'd0;
  endtask

  task automatic test_hit();
    pulse(1'b1, 1'b0);
    enter_run();
    checks++;
    if ({state_out, count_out, target_out} !== {2'd1, 4'd0, exp_target}) begin
      errors++;
      $display("FAIL hit_start got st=%0d cnt=%0d tgt=%0d exp st=1 cnt=0 tgt=%0d",
               state_out, count_out, target_out, exp_target);
    end
    play_round(exp_target, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    play_round(4'((exp_target + 6) % 10), 1'b1, 1'b0);
  endtask

  task automatic test_game_over();
    play_round(exp_target, 1'b0, 1'b1);
    repeat (3) step();
    pulse(1'b0, 1'b1);
    checks++;
    if ({state_out, game_over, score, round} !== {2'd3, 1'b1, exp_score, exp_round}) begin
      errors++;
      $display("FAIL over_frozen got st=%0d go=%0d sc=%0d rd=%0d exp st=3 go=1 sc=%0d rd=%0d",
               state_out, game_over, score, round, exp_score, exp_round);
    end
    pulse(1'b1, 1'b0);
    enter_run();
    exp_score = 4'd0;
    exp_round = 4'd0;
    checks++;
    if ({state_out, game_over, score, round, count_out, target_out} !== {2'd1, 1'b0, 12'h0, exp_target}) begin
      errors++;
      $display("FAIL restart got st=%0d go=%0d sc=%0d rd=%0d cnt=%0d tgt=%0d exp st=1 go=0 zeros tgt=%0d",
               state_out, game_over, score, round, count_out, target_out, exp_target);
    end
  endtask

  task automatic test_random_games();
    logic [3:0] c;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < NR; r++) begin
        c = ($urandom_range(0, 1) == 0) ? exp_target : 4'($urandom_range(0, 9));
        play_round(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      pulse(1'b1, 1'b0);
      enter_run();
      exp_score = 4'd0;
      exp_round = 4'd0;
      checks++;
      if ({state_out, score, round, target_out} !== {2'd1, 8'h0, exp_target}) begin
        errors++;
        $display("FAIL random_restart got st=%0d sc=%0d rd=%0d tgt=%0d exp st=1 sc=0 rd=0 tgt=%0d",
                 state_out, score, round, target_out, exp_target);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_reset_mid_run();
    test_hit();
    test_miss();
    test_game_over();
    test_random_games();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
